// File: rtl/tick_monitor_pkg.sv
// tick_monitor_pkg
//   Shared types for the tick stream monitor: the 3-bit FSM state encoding
//   and a helper that identifies the states in which the interval counter runs.
package tick_monitor_pkg;

   // Raw encodings, kept stable so status decoders elsewhere can rely on them.
   localparam logic [2:0] ENC_IDLE    = 3'd0;
   localparam logic [2:0] ENC_FIRST   = 3'd1;
   localparam logic [2:0] ENC_MEASURE = 3'd2;
   localparam logic [2:0] ENC_LOCKED  = 3'd3;
   localparam logic [2:0] ENC_LOST    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ENC_IDLE,
      ST_FIRST   = ENC_FIRST,
      ST_MEASURE = ENC_MEASURE,
      ST_LOCKED  = ENC_LOCKED,
      ST_LOST    = ENC_LOST
   } state_t;

   // States in which idle cycles are being counted and a timeout can fire.
   function automatic logic is_counting(state_t s);
      return (s == ST_FIRST) || (s == ST_MEASURE) || (s == ST_LOCKED);
   endfunction

endpackage

// File: rtl/tick_monitor_if.sv
// tick_monitor_if
//   Signal bundle between a tick source/status consumer (master) and the
//   tick_monitor (slave).
//   en, tick, limit           : master -> monitor
//   n_meas, n_valid, locked,
//   lost                      : monitor -> master
interface tick_monitor_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             tick;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] n_meas;
   logic             n_valid;
   logic             locked;
   logic             lost;

   modport master (
      output en, tick, limit,
      input  n_meas, n_valid, locked, lost
   );

   modport slave (
      input  en, tick, limit,
      output n_meas, n_valid, locked, lost
   );
endinterface

// File: rtl/tick_interval_counter.sv
// tick_interval_counter
//   Idle-cycle counter between ticks.
//   clk, rst_n : clock, async active-low reset
//   clr        : load zero (has priority over inc)
//   inc        : increment by one
//   limit      : terminal value for the compare
//   cnt        : current count
//   at_limit   : cnt == limit
module tick_interval_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             at_limit
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + WIDTH'(1);
   end

   assign at_limit = (cnt == limit);

endmodule

// File: rtl/tick_monitor.sv
// tick_monitor
//   Measures idle cycles between consecutive single-cycle ticks, declares
//   lock after two equal consecutive measurements and flags loss when the
//   gap exceeds limit.
//   clk, rst_n : clock, async active-low reset
//   bus.en     : enable; low freezes all state
//   bus.tick   : tick stream
//   bus.limit  : largest tolerated gap
//   bus.n_meas : last measured interval (idle cycles)
//   bus.n_valid: one-cycle strobe when n_meas is updated
//   bus.locked : state is LOCKED
//   bus.lost   : state is LOST
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | after reset, waiting for the first tick, no timeout
// FIRST   | counting after the first tick, no measurement yet
// MEASURE | measurements taken, last two not (yet) equal
// LOCKED  | last two measurements equal
// LOST    | gap exceeded limit, waiting for a tick to restart
module tick_monitor
   import tick_monitor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   tick_monitor_if.slave  bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] n_meas_q;
   logic             n_valid_q;
   logic             at_limit;
   logic             counting;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             take_meas;

   assign counting  = is_counting(state_q);
   assign cnt_clr   = bus.en && bus.tick;
   // Holding at limit on the timeout edge keeps cnt from ever passing limit.
   assign cnt_inc   = bus.en && !bus.tick && counting && !at_limit;
   assign take_meas = bus.en && bus.tick && counting;

   tick_interval_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .limit    (bus.limit),
      .cnt      (cnt),
      .at_limit (at_limit)
   );

   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         unique case (state_q)
            ST_IDLE, ST_LOST: begin
               if (bus.tick) state_d = ST_FIRST;
            end
            ST_FIRST: begin
               if (bus.tick)      state_d = ST_MEASURE;
               else if (at_limit) state_d = ST_LOST;
            end
            ST_MEASURE, ST_LOCKED: begin
               // Compare against the previous measurement before it is replaced.
               if (bus.tick)      state_d = (cnt == n_meas_q) ? ST_LOCKED : ST_MEASURE;
               else if (at_limit) state_d = ST_LOST;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         n_meas_q  <= '0;
         n_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_valid_q <= take_meas;
         if (take_meas)
            n_meas_q <= cnt;
      end
   end

   assign bus.n_meas  = n_meas_q;
   assign bus.n_valid = n_valid_q;
   assign bus.locked  = (state_q == ST_LOCKED);
   assign bus.lost    = (state_q == ST_LOST);

endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor
//   Directed scenarios followed by randomized tick trains, compared every
//   cycle against a measurement-level reference model.
module tb_tick_monitor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tick_monitor_if #(.WIDTH(W)) bif ();

   tick_monitor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: tracks gap since the last tick, the measurement
   // history length since (re)acquisition, and the derived status flags.
   bit m_active;
   int m_gap;
   int m_nmeas;
   int m_count;
   bit m_locked;
   bit m_lost;
   bit m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_gap = 0; m_nmeas = 0; m_count = 0;
      m_locked = 0; m_lost = 0; m_valid = 0;
   endtask

   task automatic model_edge(input bit t, input bit e, input int lim);
      m_valid = 0;
      if (!e) return;
      if (t) begin
         if (!m_active) begin
            m_active = 1; m_lost = 0; m_gap = 0; m_count = 0;
         end else begin
            m_valid  = 1;
            m_locked = (m_count >= 1) && (m_gap == m_nmeas);
            m_nmeas  = m_gap;
            m_count++;
            m_gap    = 0;
         end
      end else if (m_active) begin
         if (m_gap == lim) begin
            m_active = 0; m_lost = 1; m_locked = 0;
         end else begin
            m_gap++;
         end
      end
   endtask

   task automatic compare_all();
      chk("n_meas",  bif.n_meas,  m_nmeas);
      chk("n_valid", bif.n_valid, m_valid);
      chk("locked",  bif.locked,  m_locked);
      chk("lost",    bif.lost,    m_lost);
   endtask

   task automatic step(input bit t, input bit e);
      @(negedge clk);
      bif.tick = t;
      bif.en   = e;
      @(posedge clk);
      model_edge(t, e, int'(bif.limit));
      #1;
      compare_all();
   endtask

   task automatic gen(input int n, input int ticks);
      repeat (ticks) begin
         step(1'b1, 1'b1);
         repeat (n) step(1'b0, 1'b1);
      end
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic do_reset(input int lim);
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      bif.limit = W'(lim);
      bif.tick  = 1'b0;
      bif.en    = 1'b0;
      #1;
      chk("rst_n_meas",  bif.n_meas,  0);
      chk("rst_n_valid", bif.n_valid, 0);
      chk("rst_locked",  bif.locked,  0);
      chk("rst_lost",    bif.lost,    0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int cyc;
      bif.en = 1'b0; bif.tick = 1'b0; bif.limit = '0;
      model_reset();

      // Steady lock, N=3, limit=10
      do_reset(10);
      gen(3, 2);
      chk("pre_lock", bif.locked, 0);
      step(1'b1, 1'b1);
      chk("steady_locked", bif.locked, 1);
      chk("steady_nmeas", bif.n_meas, 3);
      repeat (3) step(1'b0, 1'b1);

      // Rate change to N=5
      repeat (2) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("rate_drop_locked", bif.locked, 0);
      chk("rate_drop_nmeas", bif.n_meas, 5);
      chk("rate_drop_valid", bif.n_valid, 1);
      repeat (5) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("rate_relock", bif.locked, 1);

      // Loss after limit+1 idle cycles, then recovery at N=3
      repeat (10) step(1'b0, 1'b1);
      chk("loss_not_yet", bif.lost, 0);
      step(1'b0, 1'b1);
      chk("loss_flag", bif.lost, 1);
      chk("loss_hold_nmeas", bif.n_meas, 5);
      gen(3, 2);
      chk("recover_nmeas", bif.n_meas, 3);
      chk("recover_not_locked", bif.locked, 0);
      step(1'b1, 1'b1);
      chk("recover_locked", bif.locked, 1);

      // Freeze mid-interval while locked
      step(1'b0, 1'b1);
      repeat (7) begin
         step(1'($urandom_range(0, 1)), 1'b0);
         chk("freeze_locked", bif.locked, 1);
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("freeze_resume_nmeas", bif.n_meas, 3);
      chk("freeze_resume_locked", bif.locked, 1);

      // Constant-high input
      do_reset(10);
      repeat (3) step(1'b1, 1'b1);
      chk("const_locked", bif.locked, 1);
      chk("const_nmeas", bif.n_meas, 0);
      repeat (4) step(1'b1, 1'b1);

      // limit = 0: any low sample after a tick is a loss
      do_reset(0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("limit0_lost", bif.lost, 1);

      // Reset mid-lock, then full relock latency at N=2
      do_reset(10);
      gen(2, 3);
      chk("midlock_locked", bif.locked, 1);
      do_reset(10);
      step(1'b1, 1'b1);
      cyc = 0;
      while (!bif.locked && cyc < 40) begin
         step(cyc % 3 == 2, 1'b1);
         cyc++;
      end
      chk("relock_cycles", cyc, 6);

      // Randomized tick trains with enable drops and forced gaps
      do_reset(8);
      for (int seg = 0; seg < 60; seg++) begin
         int n;
         int k;
         n = $urandom_range(0, 9);
         k = $urandom_range(1, 4);
         repeat (k) begin
            step(1'b1, $urandom_range(0, 9) != 0);
            repeat (n) step(1'b0, $urandom_range(0, 9) != 0);
         end
         if ($urandom_range(0, 7) == 0)
            repeat (12) step(1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Receive-side checker for the single-cycle `tick` pulse stream produced by the clock-divider tick generator. It measures the number of idle cycles between consecutive ticks and reports the divider setting N directly, so a generator programmed with N produces `n_meas = N`. It declares lock after two consecutive equal measurements and flags loss when ticks stop for longer than a programmable limit. It sits beside the divider in the lights/timing datapath as a self-check and software-visible status source.

## Interface
- `WIDTH`, default 8: width of the interval counter, `limit` and `n_meas`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  enable; when low, all state is frozen.
- `tick`  in  1  tick stream, sampled each enabled edge; every high sample counts as one tick.
- `limit`  in  WIDTH  maximum tolerated N; a larger gap means loss.
- `n_meas`  out  WIDTH  last measured interval, in N units (idle cycles between ticks).
- `n_valid`  out  1  one-cycle strobe: `n_meas` was updated at this edge.
- `locked`  out  1  high while in LOCKED.
- `lost`  out  1  high while in LOST.

## Operation
- **Counter `cnt`:**
  - Loaded with 0 on every enabled edge where `tick` = 1.
  - Incremented on every enabled edge where `tick` = 0 and state ≠ IDLE/LOST.
  - Never exceeds `limit`, because the timeout fires first; no wrap is possible.
- **States** (enum in package): IDLE, FIRST, MEASURE, LOCKED, LOST.
- **IDLE:** waits for the first tick → FIRST. No timeout in IDLE.
- **FIRST:** counting; no prior measurement exists.
  - tick → `n_meas` ← `cnt`, `n_valid` pulses, → MEASURE.
- **MEASURE:** on tick, `n_meas` ← `cnt` and `n_valid` pulses.
  - If `cnt` == old `n_meas` → LOCKED; otherwise stay in MEASURE.
- **LOCKED:** on tick, `n_meas` ← `cnt` and `n_valid` pulses.
  - If `cnt` ≠ old `n_meas` → MEASURE (lock drops); otherwise stay.
- **Timeout:** in FIRST, MEASURE or LOCKED, an enabled edge with `tick` = 0 and `cnt` == `limit` → LOST. `n_meas` holds its value.
- **LOST:** the next tick → FIRST with `cnt` = 0; no measurement is taken on that tick.
- **Back-to-back ticks** (`tick` held high) measure N = 0. A constant-high input locks with `n_meas` = 0.
- **`limit` = 0:** any low sample after a tick is a loss.
- **`limit` is sampled live.** Lowering it below the current `cnt` is not a legal input (behaviour undefined); the bench must not drive it.
- **`en` low:** `cnt`, state and `n_meas` hold. `n_valid` = 0. Ticks are ignored.
- **Reset** (asynchronous, any time, including mid-lock):
  - state = IDLE, `cnt` = 0, `n_meas` = 0.
  - `n_valid`, `locked`, `lost` = 0.
  - Ticks in the first cycle after release are sampled normally.

## Timing
- All outputs are registered. `locked` and `lost` decode from the registered state.
- A tick sampled at edge k updates `n_meas`, `n_valid` and state at edge k. They are visible in cycle k+1.
- Each `n_valid` pulse is exactly one cycle. It repeats every N+1 cycles under steady input.
- Lock latency from IDLE with period N+1: `locked` is high after the third tick edge, i.e. 2(N+1) cycles after the first tick.
- Loss: with the last tick at edge t0, `lost` is high after edge t0+limit+1.
- Mismatch: `locked` falls at the edge of the first differing tick, with the new `n_meas` and `n_valid` in the same edge.

## Structure
- `tick_monitor_pkg`: `state_t` enum (3-bit encoding).
- One natural sub-module: `tick_interval_counter`.
  - Contents: `cnt` with load-zero/increment/hold controls and a `cnt == limit` compare output.
  - The FSM and output registers stay in the top.
- Expected size: about 150–200 lines of RTL.

## Test plan
- **Steady lock:** generator N=3, `en`=1, `limit`=10 → `n_valid` every 4 cycles with `n_meas`=3; `locked`=1 from the cycle after the third tick onward.
- **Rate change:** locked at N=3, change the generator to N=5 → `locked` drops on the first tick with `n_meas`=5, and returns high on the next tick.
- **Loss and recovery:** locked at N=3, `limit`=10, stop ticks → `lost`=1 eleven cycles after the last tick. Resume at N=3 → FIRST, then `n_valid`/`n_meas`=3 one period later, and `locked` again one period after that.
- **Constant high input:** `tick` held at 1 → `n_meas`=0 with `n_valid` every cycle; `locked`=1 after the third cycle.
- **Freeze:** `en`=0 for 7 cycles while locked → outputs constant, no `n_valid`, no loss. After `en` returns, `cnt` resumes from the frozen value.
- **Reset mid-lock:** assert `rst_n`=0 between clock edges → all outputs 0 immediately and state IDLE. After release, a fresh lock takes the full 2(N+1) cycles.
